// File: rtl/debounce_pulse.sv
// Debouncer with 2-flop synchronizer: qualifies a level change for DEBOUNCE_CYCLES
// cycles, then updates `level` and pulses `enable` once on each accepted rising edge.
module debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic enable,
  output logic busy
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;

  always_comb begin
    s1_d     = btn_in;
    s2_d     = s1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    enable_d = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE_HIGH;
          enable_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they align with the state flop.
    level_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
    busy_d  = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= IDLE_LOW;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
    end
  end

  assign level  = level_q;
  assign enable = enable_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse: directed scenarios plus random runs checked
// against a run-length reference model of the debounce rules.
module tb_debounce_pulse;

  localparam int unsigned DC = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic level, enable, busy;

  int n_cmp = 0;
  int n_bad = 0;

  debounce_pulse #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .level  (level),
    .enable (enable),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Reference model: two-sample delay line, then count consecutive samples that
  // disagree with the accepted level; DC+1 in a row means the new level is accepted.
  bit dq[$] = '{1'b0, 1'b0};
  bit m_lvl = 1'b0;
  bit m_en = 1'b0;
  bit m_busy = 1'b0;
  int m_run = 0;

  function automatic void model_step(input bit r, input bit b);
    bit seen;
    if (!r) begin
      dq = '{1'b0, 1'b0};
      m_lvl = 1'b0; m_en = 1'b0; m_busy = 1'b0; m_run = 0;
    end else begin
      seen = dq.pop_front();
      dq.push_back(b);
      m_en = 1'b0;
      if (seen != m_lvl) begin
        m_run++;
        if (m_run == int'(DC) + 1) begin
          m_lvl = seen;
          m_en = seen;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run != 0);
    end
  endfunction

  task automatic tick(input bit b, input bit r);
    @(negedge clk);
    btn_in = b;
    reset = r;
    @(posedge clk);
    model_step(r, b);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_cmp++;
    if ({level, enable, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state: got l/e/b=%b%b%b want 000", level, enable, busy);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    n_cmp++;
    if ({level, enable, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle: got l/e/b=%b%b%b want 000", level, enable, busy);
    end
  endtask

  task automatic test_rise();
    logic [2:0] exp;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'b1);
      exp = {i >= 7, i == 7, (i >= 3 && i <= 6)};
      n_cmp++;
      if ({level, enable, busy} !== exp) begin
        n_bad++;
        $display("FAIL rise edge %0d: got l/e/b=%b%b%b want %b", i, level, enable, busy, exp);
      end
      n_cmp++;
      if ({level, enable, busy} !== {m_lvl, m_en, m_busy}) begin
        n_bad++;
        $display("FAIL rise_model edge %0d: got %b%b%b want %b%b%b", i, level, enable, busy,
                 m_lvl, m_en, m_busy);
      end
    end
  endtask

  task automatic test_fall();
    logic [2:0] exp;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, 1'b1);
      exp = {i < 7, 1'b0, (i >= 3 && i <= 6)};
      n_cmp++;
      if ({level, enable, busy} !== exp) begin
        n_bad++;
        $display("FAIL fall edge %0d: got l/e/b=%b%b%b want %b", i, level, enable, busy, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] exp;
    for (int i = 1; i <= 12; i++) begin
      tick(i <= 3, 1'b1);
      exp = {1'b0, 1'b0, (i >= 3 && i <= 5)};
      n_cmp++;
      if ({level, enable, busy} !== exp) begin
        n_bad++;
        $display("FAIL glitch edge %0d: got l/e/b=%b%b%b want %b", i, level, enable, busy, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    n_cmp++;
    if ({level, enable, busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid at_reset: got l/e/b=%b%b%b want 000", level, enable, busy);
    end
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b1);
      n_cmp++;
      if ({level, enable} !== {k >= 7, k == 7}) begin
        n_bad++;
        $display("FAIL reset_mid edge %0d: got l/e=%b%b want %b%b", k, level, enable,
                 k >= 7, k == 7);
      end
    end
  endtask

  task automatic test_toggle();
    for (int i = 1; i <= 20; i++) begin
      tick(i % 2 == 0, 1'b1);
      n_cmp++;
      if ({level, enable} !== 2'b10) begin
        n_bad++;
        $display("FAIL toggle edge %0d: got l/e=%b%b want 10", i, level, enable);
      end
      n_cmp++;
      if ({level, enable, busy} !== {m_lvl, m_en, m_busy}) begin
        n_bad++;
        $display("FAIL toggle_model edge %0d: got %b%b%b want %b%b%b", i, level, enable, busy,
                 m_lvl, m_en, m_busy);
      end
    end
  endtask

  task automatic test_held();
    int pulses = 0;
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
    n_cmp++;
    if (level !== 1'b0) begin
      n_bad++;
      $display("FAIL held_pre: got level=%b want 0", level);
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b1);
      if (enable === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || level !== 1'b1) begin
      n_bad++;
      $display("FAIL held_pulses: got %0d pulses level=%b want 1 pulse level=1", pulses, level);
    end
  endtask

  task automatic test_random();
    int len;
    bit b, r;
    int m_pulses = 0;
    int d_pulses = 0;
    for (int n = 0; n < 60; n++) begin
      b = 1'($urandom_range(0, 1));
      len = (n % 3 == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        r = ($urandom_range(0, 79) != 0);
        tick(b, r);
        if (m_en) m_pulses++;
        if (enable === 1'b1) d_pulses++;
        n_cmp++;
        if ({level, enable, busy} !== {m_lvl, m_en, m_busy}) begin
          n_bad++;
          $display("FAIL random run %0d step %0d: got %b%b%b want %b%b%b", n, j,
                   level, enable, busy, m_lvl, m_en, m_busy);
        end
      end
    end
    n_cmp++;
    if (d_pulses != m_pulses) begin
      n_bad++;
      $display("FAIL random_pulse_count: got %0d want %0d", d_pulses, m_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_reset_mid();
    test_toggle();
    test_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive cycles a synchronized input must hold a new level before acceptance; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled only on rising clk edge.
REQ-004 SHALL have port btn_in  input  1  raw, asynchronous, bouncy input level.
REQ-005 SHALL have port level  output  1  debounced input level; drives downstream flip-flop D.
REQ-006 SHALL have port enable  output  1  one-cycle pulse on each accepted 0->1 transition; drives downstream flip-flop enable.
REQ-007 SHALL have port busy  output  1  high while a candidate transition is being qualified.

Function
REQ-008 SHALL pass btn_in through a 2-flop synchronizer (s1, s2); the FSM SHALL use s2 only.
REQ-009 SHALL implement FSM states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-010 SHALL use a counter cnt of ceil(log2(DEBOUNCE_CYCLES)) bits, minimum 1 bit, that never wraps.
REQ-011 IDLE_LOW: s2=1 -> WAIT_HIGH, cnt<=0; else stay.
REQ-012 WAIT_HIGH: s2=0 -> IDLE_LOW, cnt<=0; s2=1 and cnt=DEBOUNCE_CYCLES-1 -> IDLE_HIGH; else cnt<=cnt+1.
REQ-013 IDLE_HIGH: s2=0 -> WAIT_LOW, cnt<=0; else stay.
REQ-014 WAIT_LOW: s2=1 -> IDLE_HIGH, cnt<=0; s2=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE_LOW; else cnt<=cnt+1.
REQ-015 level SHALL be registered: 1 in IDLE_HIGH and WAIT_LOW, 0 in IDLE_LOW and WAIT_HIGH.
REQ-016 enable SHALL be registered and high for exactly the one cycle following the WAIT_HIGH->IDLE_HIGH edge.
REQ-017 enable SHALL never assert on a 1->0 transition, a rejected glitch, or while level stays 1.
REQ-018 busy SHALL be registered and high exactly while state is WAIT_HIGH or WAIT_LOW.
REQ-019 For a clean step held stable, level and enable SHALL change DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new btn_in value; this is 7 edges at default.
REQ-020 A reversal of s2 during a WAIT state SHALL abort qualification with no output change.
REQ-021 btn_in held high indefinitely SHALL produce exactly one enable pulse.

Reset
REQ-022 With reset=0 at a rising edge: s1, s2, cnt<=0; state<=IDLE_LOW; level, enable, busy<=0.
REQ-023 Reset SHALL take priority over every transition, including mid-qualification and the enable cycle.
REQ-024 Between edges, reset SHALL have no effect on outputs; no asynchronous path.
REQ-025 After reset deassertion with btn_in already high, SHALL requalify from IDLE_LOW with full REQ-019 latency and then emit one enable pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Bench SHALL cover: reset=0 for 2 edges, btn_in=0 -> level=0, enable=0, busy=0.
REQ-027 Bench SHALL cover: btn_in 0->1 held 12 cycles -> busy high from edge 3 through edge 6; enable=1 only in cycle after edge 7; level=1 from edge 7 onward.
REQ-028 Bench SHALL cover: btn_in high 3 cycles then low -> enable never 1, level stays 0, busy pulses then returns to 0.
REQ-029 Bench SHALL cover: after stable high, btn_in 1->0 held -> level=0 after edge 7, enable stays 0.
REQ-030 Bench SHALL cover: reset=0 at edge 4 of a rising qualification, released next edge, btn_in still 1 -> busy=0 and level=0 after reset edge; enable single pulse 7 edges after release.
REQ-031 Bench SHALL cover: btn_in toggling every cycle for 20 cycles -> level, enable unchanged from prior stable values.
